// File: rtl/daq_pkg.sv
// Shared constants and types for the peak framer readout path.
// PEAK_FRAMER_CHECKSUM_EN adds the CSUM transmit state.
package daq_pkg;

    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
    localparam logic [7:0]  TRAILER_BYTE = 8'h5A;
    localparam logic [15:0] MAX_SEG_LEN  = 16'hFFFF;

    // Transmit FSM: each state names the byte currently held in the output register
    typedef enum logic [3:0] {
        TX_IDLE,
        TX_SYNC,
        TX_IDX,
        TX_LEN_H,
        TX_LEN_L,
        TX_DAT_H,
        TX_DAT_L,
        TX_TRL_SYNC,
        TX_TRL_CNT,
        TX_TRL_FLG
`ifdef PEAK_FRAMER_CHECKSUM_EN
        , TX_CSUM
`endif
    } tx_state_t;

    // Segment descriptor as stored in the descriptor buffer
    typedef struct packed {
        logic        trunc;
        logic [15:0] len;
    } seg_desc_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with async reset and full/empty.
// A write while full is discarded even if a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Extra pointer bit distinguishes full from empty
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array, no reset needed: pointers define validity
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Pointer update, emptied by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/peak_framer.sv
// Groups contiguous sample runs into segments and serializes them as framed
// byte packets, followed by a trailer after each end-of-acquisition pulse.
// Optional: PEAK_FRAMER_CHECKSUM_EN appends an XOR checksum byte per packet.
module peak_framer
    import daq_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int DESC_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       we,
    input  logic       finished,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       overflow,
    output logic       busy
);

    // ---------------- buffers ----------------
    logic       s_wr, s_rd, s_full, s_empty;
    logic [9:0] s_dout;
    logic       d_wr, d_rd, d_full, d_empty;
    seg_desc_t  d_din, d_dout;

    sync_fifo #(.WIDTH(10), .DEPTH(DEPTH)) u_smp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_wr),
        .wr_data (din),
        .rd_en   (s_rd),
        .rd_data (s_dout),
        .full    (s_full),
        .empty   (s_empty)
    );

    sync_fifo #(.WIDTH($bits(seg_desc_t)), .DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (d_wr),
        .wr_data (d_din),
        .rd_en   (d_rd),
        .rd_data (d_dout),
        .full    (d_full),
        .empty   (d_empty)
    );

    // ---------------- segment capture ----------------
    logic        seg_open, seg_open_n;
    logic        run_drop, run_drop_n;
    logic        seg_trunc, trunc_n;
    logic [15:0] seg_len, len_n;
    logic        ovf_set;

    // Open/extend/close the current segment; runs hitting a full descriptor buffer are dropped whole
    always_comb begin
        s_wr       = 1'b0;
        d_wr       = 1'b0;
        d_din      = '0;
        len_n      = seg_len;
        trunc_n    = seg_trunc;
        seg_open_n = seg_open;
        run_drop_n = run_drop;
        ovf_set    = 1'b0;
        if (seg_open) begin
            if (!we) begin
                d_wr       = 1'b1;
                d_din.trunc = seg_trunc;
                d_din.len   = seg_len;
                seg_open_n = 1'b0;
            end else begin
                s_wr = !s_full;
                if (s_full) begin
                    trunc_n = 1'b1;
                    ovf_set = 1'b1;
                end else begin
                    len_n = seg_len + 16'd1;
                end
                if (finished || len_n == MAX_SEG_LEN) begin
                    d_wr        = 1'b1;
                    d_din.trunc = trunc_n;
                    d_din.len   = len_n;
                    seg_open_n  = 1'b0;
                end
            end
        end else if (run_drop) begin
            if (we) ovf_set = 1'b1;
            if (!we || finished) run_drop_n = 1'b0;
        end else if (we) begin
            if (d_full) begin
                ovf_set    = 1'b1;
                run_drop_n = !finished;
            end else begin
                s_wr    = !s_full;
                trunc_n = s_full;
                ovf_set = s_full;
                len_n   = s_full ? 16'd0 : 16'd1;
                if (finished) begin
                    d_wr        = 1'b1;
                    d_din.trunc = trunc_n;
                    d_din.len   = len_n;
                end else begin
                    seg_open_n = 1'b1;
                end
            end
        end
    end

    // Segment capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_open  <= 1'b0;
            run_drop  <= 1'b0;
            seg_trunc <= 1'b0;
            seg_len   <= '0;
        end else begin
            seg_open  <= seg_open_n;
            run_drop  <= run_drop_n;
            seg_trunc <= trunc_n;
            seg_len   <= len_n;
        end
    end

    // ---------------- transmit ----------------
    tx_state_t   state, state_n;
    logic [7:0]  byte_n;
    logic        vld_n;
    logic        adv;
    logic [15:0] rem;
    logic        ld_rem, rem_dec;
    logic [6:0]  seg_idx;
    logic [7:0]  pkt_cnt;
    logic        idx_inc, trl_done, trl_launch;
    logic        trl_pend;
    tx_state_t   eop_state;
    logic [7:0]  eop_byte;
    logic        eop_vld, eop_launch;
`ifdef PEAK_FRAMER_CHECKSUM_EN
    logic [7:0]  csum;
    logic        trl_mode;
`endif

    // Output register may load when empty or its byte is being taken
    assign adv = !m_valid || m_ready;

    // End-of-packet decision: descriptors first, then a pending trailer
    always_comb begin
        eop_state  = TX_IDLE;
        eop_byte   = m_data;
        eop_vld    = 1'b0;
        eop_launch = 1'b0;
        if (!d_empty) begin
            eop_state = TX_SYNC;
            eop_byte  = SYNC_BYTE;
            eop_vld   = 1'b1;
        end else if (trl_pend) begin
            eop_state  = TX_TRL_SYNC;
            eop_byte   = TRAILER_BYTE;
            eop_vld    = 1'b1;
            eop_launch = 1'b1;
        end
    end

    // Next state and next output byte; the descriptor is popped once its length has been sent
    always_comb begin
        state_n    = state;
        byte_n     = m_data;
        vld_n      = m_valid;
        d_rd       = 1'b0;
        s_rd       = 1'b0;
        ld_rem     = 1'b0;
        rem_dec    = 1'b0;
        idx_inc    = 1'b0;
        trl_done   = 1'b0;
        trl_launch = 1'b0;
        if (adv) begin
            case (state)
                TX_IDLE: begin
                    state_n    = eop_state;
                    byte_n     = eop_byte;
                    vld_n      = eop_vld;
                    trl_launch = eop_launch;
                end
                TX_SYNC: begin
                    state_n = TX_IDX;
                    byte_n  = {d_dout.trunc, seg_idx};
                    idx_inc = 1'b1;
                end
                TX_IDX: begin
                    state_n = TX_LEN_H;
                    byte_n  = d_dout.len[15:8];
                end
                TX_LEN_H: begin
                    state_n = TX_LEN_L;
                    byte_n  = d_dout.len[7:0];
                    d_rd    = 1'b1;
                    ld_rem  = 1'b1;
                end
                TX_LEN_L, TX_DAT_L: begin
                    if (rem != 16'd0) begin
                        state_n = TX_DAT_H;
                        byte_n  = {6'b0, s_dout[9:8]};
                    end else begin
`ifdef PEAK_FRAMER_CHECKSUM_EN
                        state_n = TX_CSUM;
                        byte_n  = csum;
`else
                        state_n    = eop_state;
                        byte_n     = eop_byte;
                        vld_n      = eop_vld;
                        trl_launch = eop_launch;
`endif
                    end
                end
                TX_DAT_H: begin
                    state_n = TX_DAT_L;
                    byte_n  = s_dout[7:0];
                    s_rd    = 1'b1;
                    rem_dec = 1'b1;
                end
                TX_TRL_SYNC: begin
                    state_n = TX_TRL_CNT;
                    byte_n  = pkt_cnt;
                end
                TX_TRL_CNT: begin
                    state_n = TX_TRL_FLG;
                    byte_n  = {7'b0, overflow};
                end
                TX_TRL_FLG: begin
`ifdef PEAK_FRAMER_CHECKSUM_EN
                    state_n = TX_CSUM;
                    byte_n  = csum;
`else
                    trl_done   = 1'b1;
                    state_n    = eop_state;
                    byte_n     = eop_byte;
                    vld_n      = eop_vld;
                    trl_launch = eop_launch;
`endif
                end
`ifdef PEAK_FRAMER_CHECKSUM_EN
                TX_CSUM: begin
                    trl_done   = trl_mode;
                    state_n    = eop_state;
                    byte_n     = eop_byte;
                    vld_n      = eop_vld;
                    trl_launch = eop_launch;
                end
`endif
                default: begin
                    state_n = TX_IDLE;
                    vld_n   = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered output byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            state   <= state_n;
            m_data  <= byte_n;
            m_valid <= vld_n;
        end
    end

    // Remaining-sample counter for the packet in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rem <= '0;
        else if (ld_rem)  rem <= d_dout.len;
        else if (rem_dec) rem <= rem - 16'd1;
    end

    // Segment index, packet count and sticky overflow; all restart once a trailer is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_idx  <= '0;
            pkt_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (trl_done) begin
                seg_idx <= '0;
                pkt_cnt <= '0;
            end else if (idx_inc) begin
                seg_idx <= seg_idx + 7'd1;
                pkt_cnt <= pkt_cnt + 8'd1;
            end
            if (ovf_set)       overflow <= 1'b1;
            else if (trl_done) overflow <= 1'b0;
        end
    end

    // Trailer request: a repeat pulse while one is still waiting is absorbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) trl_pend <= 1'b0;
        else     trl_pend <= (trl_pend && !trl_launch) || (finished && !trl_pend);
    end

`ifdef PEAK_FRAMER_CHECKSUM_EN
    // Running XOR of every byte after the sync byte; remembers whether a trailer is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum     <= '0;
            trl_mode <= 1'b0;
        end else if (adv) begin
            case (state_n)
                TX_SYNC:          begin csum <= '0; trl_mode <= 1'b0; end
                TX_TRL_SYNC:      begin csum <= '0; trl_mode <= 1'b1; end
                TX_CSUM, TX_IDLE: csum <= csum;
                default:          csum <= csum ^ byte_n;
            endcase
        end
    end
`endif

    assign busy = seg_open || !d_empty || !s_empty || (state != TX_IDLE) || trl_pend;

endmodule
